// File: rtl/calculations_pkg.sv
// -----------------------------------------------------------------------------
// calculations_pkg
// Shared encodings for the execute-stage datapath slice:
//   - ALU operation codes (ALUOp)
//   - ALU operand-A / operand-B select codes (ALUSrcA / ALUSrcB)
//   - PC-source mux select codes (PCSrc)
// -----------------------------------------------------------------------------
package calculations_pkg;

    // ALU operation select
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_NOT   = 4'b0101;
    localparam logic [3:0] ALU_SLL   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_SLT   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    // ALU operand-A select; code 11 is a second PC encoding
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_ZERO   = 2'b01;
    localparam logic [1:0] SRCA_A      = 2'b10;
    localparam logic [1:0] SRCA_PC_ALT = 2'b11;

    // ALU operand-B select
    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_TWO  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    // PC-source mux select
    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

endpackage : calculations_pkg

// File: rtl/calculations_alu16.sv
// -----------------------------------------------------------------------------
// alu16
// Purely combinational ALU with Zero / negative / carry flag generation.
// Ports:
//   src_a, src_b  : operands
//   alu_op        : operation select (see calculations_pkg)
//   result        : ALU result, wraps modulo 2^WIDTH
//   zero          : result == 0
//   negative      : result MSB
//   carry         : carry-out of add, or no-borrow of sub; 0 otherwise
// -----------------------------------------------------------------------------
module alu16
    import calculations_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry
);

    logic [WIDTH:0]   sum_ext_s;
    logic [WIDTH:0]   diff_ext_s;
    logic [3:0]       shamt_s;
    logic             slt_s;

    assign shamt_s = src_b[3:0];

    // Extended add/subtract so the carry-out is visible as the top bit;
    // subtract is A + ~B + 1, so its carry is 1 exactly when no borrow occurs.
    always_comb begin
        sum_ext_s  = {1'b0, src_a} + {1'b0, src_b};
        diff_ext_s = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
        slt_s      = ($signed(src_a) < $signed(src_b));
    end

    // Result and carry selection by operation code
    always_comb begin
        result = {WIDTH{1'b0}};
        carry  = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                result = sum_ext_s[WIDTH-1:0];
                carry  = sum_ext_s[WIDTH];
            end
            ALU_SUB: begin
                result = diff_ext_s[WIDTH-1:0];
                carry  = diff_ext_s[WIDTH];
            end
            ALU_AND:   result = src_a & src_b;
            ALU_OR:    result = src_a | src_b;
            ALU_XOR:   result = src_a ^ src_b;
            ALU_NOT:   result = ~src_a;
            ALU_SLL:   result = src_a << shamt_s;
            ALU_SRL:   result = src_a >> shamt_s;
            ALU_SRA:   result = $unsigned($signed(src_a) >>> shamt_s);
            ALU_SLT:   result = {{(WIDTH-1){1'b0}}, slt_s};
            ALU_PASSB: result = src_b;
            default: begin
                result = {WIDTH{1'b0}};
                carry  = 1'b0;
            end
        endcase
    end

    // Status flags derived from the live result
    always_comb begin
        zero     = (result == {WIDTH{1'b0}});
        negative = result[WIDTH-1];
    end

endmodule : alu16

// File: rtl/calculations.sv
// -----------------------------------------------------------------------------
// calculations
// Execute-stage datapath slice of the 16-bit multi-cycle processor.
// Registers the register-file operands A and B, selects ALU operands,
// computes the ALU result and flags, registers the result as ALUOut and
// drives the PC-source mux.
// Ports:
//   clk, reset        : clock (rising edge), asynchronous active-low reset
//   input_A, input_B  : register-file read data
//   input_PC          : current program counter
//   input_imm         : extended immediate
//   input_ALUOp       : ALU operation select
//   input_ALUSrcA/B   : ALU operand selects
//   input_PCSrc       : PC-source mux select
//   output_ALUOut_sr  : registered ALU result
//   output_ALUMuxOut  : PC-source mux output
//   output_Zero/negative/carry : combinational ALU flags
//   output_B_sr       : registered B operand (store data)
// -----------------------------------------------------------------------------
module calculations
    import calculations_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] input_A,
    input  logic [WIDTH-1:0] input_B,
    input  logic [WIDTH-1:0] input_PC,
    input  logic [WIDTH-1:0] input_imm,
    input  logic [3:0]       input_ALUOp,
    input  logic [1:0]       input_ALUSrcA,
    input  logic [1:0]       input_ALUSrcB,
    input  logic             input_PCSrc,
    output logic [WIDTH-1:0] output_ALUOut_sr,
    output logic [WIDTH-1:0] output_ALUMuxOut,
    output logic             output_Zero,
    output logic             output_negative,
    output logic             output_carry,
    output logic [WIDTH-1:0] output_B_sr
);

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] alu_out_r;
    logic [WIDTH-1:0] src_a_s;
    logic [WIDTH-1:0] src_b_s;
    logic [WIDTH-1:0] alu_result_s;

    // Operand and result registers; load every cycle, clear asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            alu_out_r <= {WIDTH{1'b0}};
        end else begin
            a_r       <= input_A;
            b_r       <= input_B;
            alu_out_r <= alu_result_s;
        end
    end

    // Operand-A select
    always_comb begin
        src_a_s = input_PC;
        case (input_ALUSrcA)
            SRCA_PC:     src_a_s = input_PC;
            SRCA_ZERO:   src_a_s = {WIDTH{1'b0}};
            SRCA_A:      src_a_s = a_r;
            SRCA_PC_ALT: src_a_s = input_PC;
            default:     src_a_s = input_PC;
        endcase
    end

    // Operand-B select; IMM2 is the immediate scaled to a halfword offset
    always_comb begin
        src_b_s = b_r;
        case (input_ALUSrcB)
            SRCB_B:    src_b_s = b_r;
            SRCB_TWO:  src_b_s = {{(WIDTH-2){1'b0}}, 2'b10};
            SRCB_IMM:  src_b_s = input_imm;
            SRCB_IMM2: src_b_s = {input_imm[WIDTH-2:0], 1'b0};
            default:   src_b_s = b_r;
        endcase
    end

    alu16 #(
        .WIDTH (WIDTH)
    ) u_alu (
        .src_a    (src_a_s),
        .src_b    (src_b_s),
        .alu_op   (input_ALUOp),
        .result   (alu_result_s),
        .zero     (output_Zero),
        .negative (output_negative),
        .carry    (output_carry)
    );

    // PC-source mux: live result or the value registered last cycle
    always_comb begin
        if (input_PCSrc == PCSRC_ALUOUT) begin
            output_ALUMuxOut = alu_out_r;
        end else begin
            output_ALUMuxOut = alu_result_s;
        end
    end

    assign output_ALUOut_sr = alu_out_r;
    assign output_B_sr      = b_r;

endmodule : calculations

// File: tb/tb_calculations.sv
module tb_calculations;

    logic        clk;
    logic        reset;
    logic [15:0] input_A;
    logic [15:0] input_B;
    logic [15:0] input_PC;
    logic [15:0] input_imm;
    logic [3:0]  input_ALUOp;
    logic [1:0]  input_ALUSrcA;
    logic [1:0]  input_ALUSrcB;
    logic        input_PCSrc;
    logic [15:0] output_ALUOut_sr;
    logic [15:0] output_ALUMuxOut;
    logic        output_Zero;
    logic        output_negative;
    logic        output_carry;
    logic [15:0] output_B_sr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    calculations #(.WIDTH(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .input_A          (input_A),
        .input_B          (input_B),
        .input_PC         (input_PC),
        .input_imm        (input_imm),
        .input_ALUOp      (input_ALUOp),
        .input_ALUSrcA    (input_ALUSrcA),
        .input_ALUSrcB    (input_ALUSrcB),
        .input_PCSrc      (input_PCSrc),
        .output_ALUOut_sr (output_ALUOut_sr),
        .output_ALUMuxOut (output_ALUMuxOut),
        .output_Zero      (output_Zero),
        .output_negative  (output_negative),
        .output_carry     (output_carry),
        .output_B_sr      (output_B_sr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // advance one rising edge, then settle 1 time unit
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        input_A = 16'h0000; input_B = 16'h0000;
        input_PC = 16'h0000; input_imm = 16'h0000;
        input_ALUOp = 4'b0000; input_ALUSrcA = 2'b10; input_ALUSrcB = 2'b00;
        input_PCSrc = 1'b0;
        #12;
        // reset state
        check("rst_aluout", output_ALUOut_sr, 16'h0000);
        check("rst_bsr",    output_B_sr,      16'h0000);
        check("rst_mux",    output_ALUMuxOut, 16'h0000);
        check("rst_zero",   {15'h0, output_Zero}, 16'h0001);

        // 1. add A+B
        @(negedge clk);
        reset = 1'b1;
        input_A = 16'h0001; input_B = 16'h0002;
        step(); step(); step();
        check("add1_mux",  output_ALUMuxOut, 16'h0003);
        check("add1_zero", {15'h0, output_Zero}, 16'h0000);
        check("add1_neg",  {15'h0, output_negative}, 16'h0000);
        check("add1_aluout", output_ALUOut_sr, 16'h0003);
        input_A = 16'h1234; input_B = 16'h5678;
        step();
        check("add2_mux",   output_ALUMuxOut, 16'h68AC);
        check("add2_carry", {15'h0, output_carry}, 16'h0000);
        check("add2_aluout_lag", output_ALUOut_sr, 16'h0003);
        step();
        check("add2_aluout", output_ALUOut_sr, 16'h68AC);
        // add carry-out boundary
        input_A = 16'hFFFF; input_B = 16'h0001;
        step();
        check("addc_mux",   output_ALUMuxOut, 16'h0000);
        check("addc_carry", {15'h0, output_carry}, 16'h0001);
        check("addc_zero",  {15'h0, output_Zero}, 16'h0001);

        // 2. subtract immediate
        input_A = 16'h0BCD; input_imm = 16'h0111;
        input_ALUOp = 4'b0001; input_ALUSrcB = 2'b10;
        step();
        check("subi_mux",   output_ALUMuxOut, 16'h0ABC);
        check("subi_zero",  {15'h0, output_Zero}, 16'h0000);
        check("subi_neg",   {15'h0, output_negative}, 16'h0000);
        check("subi_carry", {15'h0, output_carry}, 16'h0001);

        // 3. PC increment (combinational)
        input_PC = 16'h1234; input_ALUSrcA = 2'b00; input_ALUSrcB = 2'b01;
        input_ALUOp = 4'b0000;
        #1;
        check("pcinc_mux", output_ALUMuxOut, 16'h1236);
        step();
        check("pcinc_aluout", output_ALUOut_sr, 16'h1236);
        input_PCSrc = 1'b1;
        #1;
        check("pcsrc1_mux", output_ALUMuxOut, 16'h1236);
        input_PCSrc = 1'b0;

        // shift / compare / misc ops on A_sr=8000, B_sr=0004
        input_A = 16'h8000; input_B = 16'h0004;
        input_ALUSrcA = 2'b10; input_ALUSrcB = 2'b00;
        step();
        input_ALUOp = 4'b1000; #1; check("sra",  output_ALUMuxOut, 16'hF800);
        input_ALUOp = 4'b0111; #1; check("srl",  output_ALUMuxOut, 16'h0800);
        input_ALUOp = 4'b0110; #1; check("sll",  output_ALUMuxOut, 16'h0000);
        input_ALUOp = 4'b1001; #1; check("slt",  output_ALUMuxOut, 16'h0001);
        input_ALUOp = 4'b0101; #1; check("not",  output_ALUMuxOut, 16'h7FFF);
        input_ALUOp = 4'b0100; #1; check("xor",  output_ALUMuxOut, 16'h8004);
        input_ALUOp = 4'b1011; #1; check("inv_op", output_ALUMuxOut, 16'h0000);
        input_ALUOp = 4'b1010; input_ALUSrcA = 2'b01; input_ALUSrcB = 2'b11;
        input_imm = 16'h0111;
        #1; check("passb_imm2", output_ALUMuxOut, 16'h0222);

        // 4. zero flag from sub
        input_ALUSrcA = 2'b10; input_ALUSrcB = 2'b00; input_ALUOp = 4'b0001;
        input_A = 16'h5555; input_B = 16'h5555;
        step();
        check("subz_mux",  output_ALUMuxOut, 16'h0000);
        check("subz_zero", {15'h0, output_Zero}, 16'h0001);
        check("subz_neg",  {15'h0, output_negative}, 16'h0000);

        // 5. negative flag
        input_B = 16'h5585;
        step();
        check("subn_mux",   output_ALUMuxOut, 16'hFFD0);
        check("subn_zero",  {15'h0, output_Zero}, 16'h0000);
        check("subn_neg",   {15'h0, output_negative}, 16'h0001);
        check("subn_carry", {15'h0, output_carry}, 16'h0000);
        check("subn_bsr",   output_B_sr, 16'h5585);
        step();
        check("subn_aluout", output_ALUOut_sr, 16'hFFD0);

        // 6. asynchronous reset between edges
        #2;
        reset = 1'b0;
        input_ALUOp = 4'b0000;
        #1;
        check("arst_aluout", output_ALUOut_sr, 16'h0000);
        check("arst_bsr",    output_B_sr,      16'h0000);
        check("arst_mux",    output_ALUMuxOut, 16'h0000);
        check("arst_zero",   {15'h0, output_Zero}, 16'h0001);
        step();
        check("arst_hold", output_ALUOut_sr, 16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_calculations

// File: doc/calculations.md
Name: calculations

Overview:
- Execute-stage datapath slice of the 16-bit multi-cycle processor.
- Registers the register-file read operands A and B.
- Selects the ALU operands from A/PC and B/constant-2/immediate, computes the ALU result and its Zero/negative/carry flags, and registers the result as ALUOut.
- Drives the PC-source mux output: either the live ALU result or the registered ALUOut.

Parameters:
- WIDTH, 16, datapath width. All data ports use it. Only 16 is required to work.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- input_A  input  16  register-file read data A.
- input_B  input  16  register-file read data B.
- input_PC  input  16  current program counter.
- input_imm  input  16  immediate, already extended by the decode stage.
- input_ALUOp  input  4  ALU operation select.
- input_ALUSrcA  input  2  ALU operand-A select.
- input_ALUSrcB  input  2  ALU operand-B select.
- input_PCSrc  input  1  PC-source mux select.
- output_ALUOut_sr  output  16  registered ALU result.
- output_ALUMuxOut  output  16  PC-source mux output.
- output_Zero  output  1  ALU result equals 0.
- output_negative  output  1  ALU result bit 15.
- output_carry  output  1  ALU carry-out.
- output_B_sr  output  16  registered B operand, used as store data.

Behaviour:
- Registers: A_sr, B_sr and ALUOut_sr.
  - Each one loads unconditionally on every rising clk: A_sr<=input_A, B_sr<=input_B, ALUOut_sr<=ALU result.
  - When reset is low, all three clear to 0 immediately, independent of clk, and hold 0 while reset stays low.
- output_B_sr = B_sr. output_ALUOut_sr = ALUOut_sr.
- ALUSrcA mux:
  - 00 -> input_PC
  - 01 -> 16'h0000
  - 10 -> A_sr
  - 11 -> input_PC
- ALUSrcB mux:
  - 00 -> B_sr
  - 01 -> 16'h0002
  - 10 -> input_imm
  - 11 -> input_imm<<1, low bit 0
- The ALU is combinational on (srcA, srcB). Result is 16 bits; arithmetic wraps modulo 2^16.
- ALUOp encoding:
  - 0000 add
  - 0001 sub (srcA - srcB)
  - 0010 and
  - 0011 or
  - 0100 xor
  - 0101 not srcA
  - 0110 sll (srcA << srcB[3:0])
  - 0111 srl (logical)
  - 1000 sra (arithmetic)
  - 1001 slt (signed; result 1 if srcA<srcB, else 0)
  - 1010 pass srcB
  - 1011-1111 -> result 0
- Flags are combinational from the current ALU result (not registered):
  - Zero = (result == 0).
  - negative = result[15].
  - carry, add: bit 16 of the 17-bit sum.
  - carry, sub: bit 16 of srcA + ~srcB + 1, i.e. 1 when no borrow.
  - carry, all other ops: 0.
- output_ALUMuxOut: PCSrc 0 -> combinational ALU result; PCSrc 1 -> ALUOut_sr.
- Latency from input_A/input_B:
  - To ALUMuxOut (PCSrc=0) and the flags: 1 rising edge.
  - To ALUOut_sr: 2 rising edges.
- input_PC, input_imm and the select lines act combinationally, with no latency.
- During reset: A_sr and B_sr read as 0, so with ALUSrcA=10/ALUSrcB=00, add gives result 0 and Zero=1.
- Release of reset has no extra latency; the first rising edge after release loads the registers.

Decomposition:
- Package calculations_pkg holds:
  - ALUOp localparams (ALU_ADD ... ALU_PASSB).
  - ALUSrcA/ALUSrcB select codes (SRCA_PC, SRCA_ZERO, SRCA_A; SRCB_B, SRCB_TWO, SRCB_IMM, SRCB_IMM2).
  - PCSrc codes.
- One sub-module, alu16: the purely combinational ALU plus flag generation.
- The top level contains the registers and muxes.

Test Plan:
1. Add of A and B: reset pulse low then high; A=0001, B=0002, ALUOp=0000, SrcA=10, SrcB=00, PCSrc=0. After 3 clocks -> ALUMuxOut=0003, Zero=0, negative=0. Then A=1234, B=5678 -> 68AC, carry=0.
2. Subtract immediate: A=0BCD, imm=0111, ALUOp=0001, SrcA=10, SrcB=10 -> ALUMuxOut=0ABC, Zero=0, negative=0, carry=1.
3. PC increment: PC=1234, SrcA=00, SrcB=01, add -> ALUMuxOut=1236 immediately. ALUOut_sr=1236 after the next edge. With PCSrc=1, ALUMuxOut=1236.
4. Zero flag: A=B=5555, sub, SrcA=10, SrcB=00 -> ALUMuxOut=0000, Zero=1, negative=0.
5. Negative flag: A=5555, B=5585, sub -> ALUMuxOut=FFD0, Zero=0, negative=1, carry=0. Also check output_B_sr=5585.
6. Asynchronous reset mid-run: after scenario 5, drive reset low between edges -> ALUOut_sr and B_sr read 0000 at once without a clock edge. ALUMuxOut with SrcA=10/SrcB=00 add -> 0000, Zero=1.
